multi_ticker: RTL and testbench

MULTI_TICKER -- requirements
Module: multi_ticker

---
 rtl/multi_ticker.sv | 129 ++++++++++++
 tb/tb_multi_ticker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ticker.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | multi_ticker : CHANNELS independent programmable tick generators that share  |
// |                one load strobe. Optional build macro                          |
// |                MULTI_TICKER_TICKCOUNT_EN adds saturating per-channel tick     |
// |                counters.                                                      |
// | Revision     : 1.0                                                            |
// +------------------------------------------------------------------------------+
module multi_ticker #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS-1:0]       oneshot_i,
  input  logic                      load_i,
  input  logic [CHANNELS*WIDTH-1:0] period_i,
  output logic [CHANNELS-1:0]       tick_o,
  output logic [CHANNELS-1:0]       busy_o
`ifdef MULTI_TICKER_TICKCOUNT_EN
  ,
  output logic [CHANNELS*CNT_WIDTH-1:0] tick_cnt_o
`endif
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  if (CHANNELS < 1 || CHANNELS > 16 || WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_params
    $error("multi_ticker: parameter out of range");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             en_q;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             w_rise;
    logic [WIDTH-1:0] w_cnt_cur;
    logic             w_armed_cur;

    assign w_rise = en_i[i] & ~en_q;

    // An enable rising edge restarts from zero and counts on that same edge,
    // so a period of P produces its first tick P-1 edges later.
    always_comb begin
      period_d    = period_q;
      cnt_d       = cnt_q;
      armed_d     = armed_q;
      tick_d      = 1'b0;
      w_cnt_cur   = w_rise ? '0 : cnt_q;
      w_armed_cur = armed_q | w_rise;
      if (load_i) begin
        period_d = period_i[i*WIDTH +: WIDTH];
        cnt_d    = '0;
        armed_d  = 1'b1;
      end else if (!en_i[i]) begin
        cnt_d = '0;
      end else begin
        cnt_d   = w_cnt_cur;
        armed_d = w_armed_cur;
        if (w_armed_cur && (period_q != '0)) begin
          if (w_cnt_cur == period_q - C_ONE) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (oneshot_i[i]) begin
              armed_d = 1'b0;
            end
          end else begin
            cnt_d = w_cnt_cur + C_ONE;
          end
        end
      end
      busy_d = en_i[i] & armed_d & (period_d != '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        period_q <= '0;
        cnt_q    <= '0;
        armed_q  <= 1'b0;
        en_q     <= 1'b0;
        tick_q   <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        period_q <= period_d;
        cnt_q    <= cnt_d;
        armed_q  <= armed_d;
        en_q     <= en_i[i];
        tick_q   <= tick_d;
        busy_q   <= busy_d;
      end
    end

    assign tick_o[i] = tick_q;
    assign busy_o[i] = busy_q;

`ifdef MULTI_TICKER_TICKCOUNT_EN
    localparam logic [CNT_WIDTH-1:0] C_TCNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] C_TCNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;

    always_comb begin
      tcnt_d = tcnt_q;
      if (load_i) begin
        tcnt_d = '0;
      end else if (tick_d && (tcnt_q != C_TCNT_MAX)) begin
        tcnt_d = tcnt_q + C_TCNT_ONE;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        tcnt_q <= '0;
      end else begin
        tcnt_q <= tcnt_d;
      end
    end

    assign tick_cnt_o[i*CNT_WIDTH +: CNT_WIDTH] = tcnt_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_ticker.sv
`default_nettype none
// Self-checking bench for multi_ticker: directed scenarios plus randomized traffic
// compared cycle by cycle against an arithmetic reference model.
module tb_multi_ticker;
  localparam int CH = 4;
  localparam int W  = 16;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH-1:0]     en = '0;
  logic [CH-1:0]     os = '0;
  logic              ld = 1'b0;
  logic [CH*W-1:0]   per = '0;
  logic [CH-1:0]     tick;
  logic [CH-1:0]     busy;
`ifdef MULTI_TICKER_TICKCOUNT_EN
  logic [CH*CW-1:0]  tcnt;
`endif

  multi_ticker #(.CHANNELS(CH), .WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .en_i      (en),
    .oneshot_i (os),
    .load_i    (ld),
    .period_i  (per),
    .tick_o    (tick),
    .busy_o    (busy)
`ifdef MULTI_TICKER_TICKCOUNT_EN
    ,
    .tick_cnt_o(tcnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a channel ticks when the number of counting edges since it
  // was (re)started, taken modulo the period, reaches period-1.
  int          m_preg [CH];
  int          m_since[CH];
  int          m_tcnt [CH];
  bit          m_armed[CH];
  bit          m_prev [CH];
  logic [CH-1:0] m_tick;
  logic [CH-1:0] m_busy;
  int          seen[CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_preg[c] = 0; m_since[c] = 0; m_tcnt[c] = 0; m_armed[c] = 0; m_prev[c] = 0;
    end
    m_tick = '0;
    m_busy = '0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      bit rise;
      rise      = en[c] && !m_prev[c];
      m_tick[c] = 1'b0;
      if (ld) begin
        m_preg[c]  = int'(per[c*W +: W]);
        m_since[c] = 0;
        m_armed[c] = 1;
      end else if (!en[c]) begin
        m_since[c] = 0;
      end else begin
        if (rise) begin
          m_armed[c] = 1;
          m_since[c] = 0;
        end
        if (m_armed[c] && m_preg[c] != 0) begin
          if (m_since[c] % m_preg[c] == m_preg[c] - 1) begin
            m_tick[c] = 1'b1;
            if (os[c]) m_armed[c] = 0;
          end
          m_since[c]++;
        end
      end
      m_prev[c] = en[c];
      m_busy[c] = en[c] && m_armed[c] && (m_preg[c] != 0);
      if (ld) m_tcnt[c] = 0;
      else if (m_tick[c] && m_tcnt[c] < (1 << CW) - 1) m_tcnt[c]++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("tick", 32'(tick), 32'(m_tick));
    check("busy", 32'(busy), 32'(m_busy));
`ifdef MULTI_TICKER_TICKCOUNT_EN
    for (int c = 0; c < CH; c++) check("tick_cnt", 32'(tcnt[c*CW +: CW]), 32'(m_tcnt[c]));
`endif
    for (int c = 0; c < CH; c++) seen[c] += int'(tick[c]);
  endtask

  task automatic clear_seen();
    for (int c = 0; c < CH; c++) seen[c] = 0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    model_reset();
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_per(input int p0, input int p1, input int p2, input int p3);
    per = {W'(p3), W'(p2), W'(p1), W'(p0)};
  endtask

  initial begin
    int k;
    model_reset();
    clear_seen();
    @(negedge clk);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // No ticks after reset without a load, even with a period on the bus.
    set_per(1, 2, 3, 4); en = 4'hF;
    clear_seen();
    repeat (8) cycle();
    check("no_load_ticks", 32'(seen[0] + seen[1] + seen[2] + seen[3]), 32'd0);

    // Periods {1,3,5,0}, all enabled, periodic.
    set_per(1, 3, 5, 0); ld = 1'b1; os = '0;
    cycle();
    ld = 1'b0;
    clear_seen();
    repeat (30) cycle();
    check("p1_count", 32'(seen[0]), 32'd30);
    check("p3_count", 32'(seen[1]), 32'd10);
    check("p5_count", 32'(seen[2]), 32'd6);
    check("p0_count", 32'(seen[3]), 32'd0);
    check("p0_busy", 32'(busy[3]), 32'd0);

    // One-shot, period 4.
    en = '0; set_per(4, 0, 0, 0); os = 4'b0001; ld = 1'b1;
    cycle();
    ld = 1'b0; en = 4'b0001;
    clear_seen();
    repeat (12) cycle();
    check("oneshot_count", 32'(seen[0]), 32'd1);
    check("oneshot_busy", 32'(busy[0]), 32'd0);
    en = '0;
    cycle();
    en = 4'b0001;
    clear_seen();
    repeat (10) cycle();
    check("oneshot_rearm", 32'(seen[0]), 32'd1);

    // Reload at terminal count.
    os = '0; set_per(10, 0, 0, 0); ld = 1'b1;
    cycle();
    ld = 1'b0;
    repeat (9) cycle();
    set_per(6, 0, 0, 0); ld = 1'b1;
    cycle();
    check("load_no_tick", 32'(tick[0]), 32'd0);
    ld = 1'b0;
    k = 0;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      if (tick[0]) begin k = n; break; end
    end
    check("reload_latency", 32'(k), 32'd6);

    // Enable glitch at cnt=1, period 2.
    set_per(2, 0, 0, 0); ld = 1'b1;
    cycle();
    ld = 1'b0;
    cycle();
    en = '0;
    cycle();
    check("glitch_no_tick", 32'(tick[0]), 32'd0);
    en = 4'b0001;
    k = 0;
    for (int n = 1; n <= 10; n++) begin
      cycle();
      if (tick[0]) begin k = n; break; end
    end
    check("reenable_latency", 32'(k), 32'd2);

    // Reset mid-count, period 8.
    set_per(8, 0, 0, 0); ld = 1'b1;
    cycle();
    ld = 1'b0;
    repeat (5) cycle();
    do_reset(3);
    clear_seen();
    repeat (20) cycle();
    check("post_reset_ticks", 32'(seen[0]), 32'd0);

`ifdef MULTI_TICKER_TICKCOUNT_EN
    set_per(1, 0, 0, 0); ld = 1'b1;
    cycle();
    ld = 1'b0;
    repeat (12) cycle();
    check("tcnt_sat", 32'(tcnt[CW-1:0]), 32'd7);
    ld = 1'b1;
    cycle();
    ld = 1'b0;
    check("tcnt_clear", 32'(tcnt[CW-1:0]), 32'd0);
`endif

    // Randomized traffic: sticky enables, random modes, sparse loads, period bus
    // changing every cycle, occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset(1 + $urandom_range(0, 2));
        continue;
      end
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0) en[c] = ~en[c];
        per[c*W +: W] = W'($urandom_range(0, 6));
      end
      os = CH'($urandom);
      ld = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
